// File: rtl/pulso_medidor.sv
// pulso_medidor: measures the width of a high pulse on Pin in Clk cycles, strobing Valid or Glitch.
// Define PULSO_MEDIDOR_SYNC_EN to pass Pin through a 2-flop synchronizer (adds 2 cycles of latency).
module pulso_medidor #(
    parameter int W     = 18,
    parameter int MIN_W = 2
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         Pin,
    output logic [W-1:0] Width,
    output logic         Valid,
    output logic         Ovf,
    output logic         Busy,
    output logic         Glitch
);
    typedef enum logic {IDLE, MEAS} state_t;
    state_t state, state_nxt;
    logic cur, prev, rise, fall, sat;
    logic [W-1:0] cnt, cnt_nxt, width_nxt;
    logic ovf_nxt, valid_nxt, glitch_nxt;
`ifdef PULSO_MEDIDOR_SYNC_EN
    logic [1:0] sync;
    // Reset to 1 so a line already high at reset release is not taken as a rise
    always_ff @(posedge Clk)
        sync <= Rst ? 2'b11 : {sync[0], Pin};
    assign cur = sync[1];
`else
    assign cur = Pin;
`endif
    assign rise = cur & ~prev;
    assign fall = ~cur & prev;
    assign sat  = &cnt;
    assign Busy = state == MEAS;
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        width_nxt  = Width;
        ovf_nxt    = Ovf;
        valid_nxt  = 1'b0;
        glitch_nxt = 1'b0;
        if (state == IDLE) begin
            if (rise) begin
                state_nxt = MEAS;
                cnt_nxt   = W'(1);
            end
        end else if (fall) begin
            state_nxt  = IDLE;
            cnt_nxt    = '0;
            valid_nxt  = cnt >= W'(MIN_W);
            glitch_nxt = cnt < W'(MIN_W);
            width_nxt  = valid_nxt ? cnt : Width;
            ovf_nxt    = valid_nxt ? sat : Ovf;
        end else if (!sat) begin
            cnt_nxt = cnt + W'(1);
        end
    end
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state  <= IDLE;
            cnt    <= '0;
            prev   <= 1'b1;
            Width  <= '0;
            Ovf    <= 1'b0;
            Valid  <= 1'b0;
            Glitch <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            prev   <= cur;
            Width  <= width_nxt;
            Ovf    <= ovf_nxt;
            Valid  <= valid_nxt;
            Glitch <= glitch_nxt;
        end
    end
endmodule

// File: tb/tb_pulso_medidor.sv
// tb_pulso_medidor: randomized and directed pulses checked every cycle against a pulse-level model.
// Two instances share Pin: default W=18 and a narrow W=4 one to exercise saturation.
module tb_pulso_medidor;
`ifdef PULSO_MEDIDOR_SYNC_EN
    localparam int D = 2;
`else
    localparam int D = 0;
`endif
    logic clk = 0, rst = 1, pin = 0;
    logic [17:0] width0;
    logic [3:0]  width1;
    logic valid0, ovf0, busy0, glitch0, valid1, ovf1, busy1, glitch1;
    int checks = 0, errors = 0, cyc = 0;
    int vcnt0 = 0, gcnt0 = 0, vcnt1 = 0, gcnt1 = 0, busy_n = 0, valid_cyc = 0, fall_cyc = 0;
    int w_prev = 0, w_last = 0;
    bit armed = 0;

    pulso_medidor #(.W(18), .MIN_W(2)) dut0 (.Clk(clk), .Rst(rst), .Pin(pin), .Width(width0),
        .Valid(valid0), .Ovf(ovf0), .Busy(busy0), .Glitch(glitch0));
    pulso_medidor #(.W(4), .MIN_W(2)) dut1 (.Clk(clk), .Rst(rst), .Pin(pin), .Width(width1),
        .Valid(valid1), .Ovf(ovf1), .Busy(busy1), .Glitch(glitch1));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: track runs of high samples on the sampled line and judge each run when it ends
    longint mx[2] = '{262143, 15};
    longint run = 0, ew[2];
    bit p1 = 1, p2 = 1, prevc = 1, started = 0, c;
    bit ev[2], eo[2], eg[2], eb[2];
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            p1 = 1; p2 = 1; prevc = 1; started = 0; run = 0; armed = 1;
            for (int i = 0; i < 2; i++) begin
                ew[i] = 0; eo[i] = 0; ev[i] = 0; eg[i] = 0; eb[i] = 0;
            end
        end else begin
            c = (D == 2) ? p2 : pin;
            p2 = p1;
            p1 = pin;
            ev = '{0, 0};
            eg = '{0, 0};
            if (c && !prevc) begin
                started = 1; run = 1;
            end else if (c && started) begin
                run++;
            end else if (!c && prevc && started) begin
                started = 0;
                for (int i = 0; i < 2; i++) begin
                    if (run >= 2) begin
                        ev[i] = 1;
                        ew[i] = run > mx[i] ? mx[i] : run;
                        eo[i] = run >= mx[i];
                    end else begin
                        eg[i] = 1;
                    end
                end
            end
            eb = '{started, started};
            prevc = c;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("width0", 64'(width0), 64'(ew[0]));
            chk("ovf0", 64'(ovf0), 64'(eo[0]));
            chk("valid0", 64'(valid0), 64'(ev[0]));
            chk("glitch0", 64'(glitch0), 64'(eg[0]));
            chk("busy0", 64'(busy0), 64'(eb[0]));
            chk("width1", 64'(width1), 64'(ew[1]));
            chk("ovf1", 64'(ovf1), 64'(eo[1]));
            chk("valid1", 64'(valid1), 64'(ev[1]));
            chk("glitch1", 64'(glitch1), 64'(eg[1]));
            chk("busy1", 64'(busy1), 64'(eb[1]));
            if (valid0) begin
                vcnt0++; w_prev = w_last; w_last = int'(width0); valid_cyc = cyc;
            end
            if (glitch0) gcnt0++;
            if (valid1) vcnt1++;
            if (glitch1) gcnt1++;
            if (busy0) busy_n++;
        end
    end

    task automatic drive(input logic p, input logic r);
        @(negedge clk);
        pin = p;
        rst = r;
    endtask

    task automatic pulse(input int hi, input int lo);
        for (int i = 0; i < hi; i++) drive(1, 0);
        drive(0, 0);
        fall_cyc = cyc;
        for (int i = 1; i < lo; i++) drive(0, 0);
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
        #1;
    endtask

    int v0, g0, v1, g1, b0;
    initial begin
        repeat (3) drive(0, 1);
        drive(0, 0);
        settle();
        chk("reset_width", 64'(width0), 64'd0);
        chk("reset_busy", 64'(busy0), 64'd0);
        v0 = vcnt0; b0 = busy_n;
        pulse(5, 6);
        settle();
        chk("p5_valids", 64'(vcnt0 - v0), 64'd1);
        chk("p5_width", 64'(width0), 64'd5);
        chk("p5_ovf", 64'(ovf0), 64'd0);
        chk("p5_busy_cycles", 64'(busy_n - b0), 64'd5);
        chk("p5_latency", 64'(valid_cyc - fall_cyc), 64'(1 + D));
        v0 = vcnt0; g0 = gcnt0;
        pulse(1, 6);
        settle();
        chk("glitch_count", 64'(gcnt0 - g0), 64'd1);
        chk("glitch_no_valid", 64'(vcnt0 - v0), 64'd0);
        chk("glitch_width_held", 64'(width0), 64'd5);
        v0 = vcnt0;
        pulse(3, 1);
        pulse(4, 6);
        settle();
        chk("b2b_valids", 64'(vcnt0 - v0), 64'd2);
        chk("b2b_first", 64'(w_prev), 64'd3);
        chk("b2b_second", 64'(w_last), 64'd4);
        pulse(20, 6);
        settle();
        chk("sat_width1", 64'(width1), 64'd15);
        chk("sat_ovf1", 64'(ovf1), 64'd1);
        chk("wide_width0", 64'(width0), 64'd20);
        pulse(3, 6);
        settle();
        chk("post_sat_width1", 64'(width1), 64'd3);
        chk("post_sat_ovf1", 64'(ovf1), 64'd0);
        v0 = vcnt0; g0 = gcnt0; v1 = vcnt1; g1 = gcnt1;
        repeat (3) drive(1, 1);
        b0 = busy_n;
        repeat (10) drive(1, 0);
        repeat (5) drive(0, 0);
        settle();
        chk("held_strobes0", 64'(vcnt0 - v0 + gcnt0 - g0), 64'd0);
        chk("held_strobes1", 64'(vcnt1 - v1 + gcnt1 - g1), 64'd0);
        chk("held_busy", 64'(busy_n - b0), 64'd0);
        v0 = vcnt0; g0 = gcnt0;
        pulse(3, 1);
        repeat (3) drive(1, 0);
        drive(1, 1);
        repeat (6) drive(1, 0);
        repeat (5) drive(0, 0);
        settle();
        chk("abort_strobes", 64'(vcnt0 - v0 + gcnt0 - g0 - 1), 64'd0);
        chk("abort_width", 64'(width0), 64'd0);
        pulse(6, 6);
        settle();
        chk("after_abort_width", 64'(width0), 64'd6);
        chk("after_abort_latency", 64'(valid_cyc - fall_cyc), 64'(1 + D));
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 40) == 0) drive(pin, 1);
            pulse(($urandom_range(0, 9) == 0) ? int'($urandom_range(14, 20)) : int'($urandom_range(1, 6)),
                  int'($urandom_range(1, 3)));
        end
        settle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
